multi_ramp_counter: RTL and testbench

//  N-channel single-slope converter: measures each joystick/triangle comparator output by counting.
//  - Owns the ramp timing and drives ramp_up to the external triangle generator.
//  - Captures every channel's count at its comparator's falling edge.
//  - Publishes all channels together once per ramp period.
//  - Sits between the analog comparator bank and the display refresh logic.

---
 rtl/multi_ramp_counter_pkg.sv | 7 +
 rtl/multi_ramp_counter_capture.sv | 46 ++++
 rtl/multi_ramp_counter.sv | 78 +++++++
 tb/tb_multi_ramp_counter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/multi_ramp_counter_pkg.sv
// multi_ramp_counter_pkg: shared FSM state type and width helper for the ramp converter
package multi_ramp_counter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/multi_ramp_counter_capture.sv
// ramp_chan_capture: per-channel comparator synchroniser, first-fall capture and over/under flags
module ramp_chan_capture #(
  parameter int WIDTH       = 7,
  parameter int MAX_COUNT   = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             comp,
  input  logic [WIDTH-1:0] count,
  input  logic             arm,
  input  logic             in_up,
  input  logic             last_tick,
  output logic [WIDTH-1:0] res_val,
  output logic             res_over,
  output logic             res_under
);
  logic [SYNC_STAGES-1:0] sync;
  logic [WIDTH-1:0] val;
  logic cs, armed, first, ovr, und, cap, sat;
  // res_* is what this channel holds after the current edge, so a capture on the last tick still publishes
  always_comb begin
    cs = sync[SYNC_STAGES-1];
    cap = in_up && armed && !cs;
    sat = in_up && armed && cs && last_tick;
    res_val = cap ? count : sat ? WIDTH'(MAX_COUNT) : val;
    res_over = !cap && (sat || ovr);
    res_under = cap ? first : und;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      armed <= 1'b0;
      first <= 1'b0;
      val <= '0;
      ovr <= 1'b0;
      und <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], comp};
      first <= arm;
      armed <= arm || (armed && !cap && !sat);
      val <= arm ? '0 : res_val;
      ovr <= !arm && res_over;
      und <= !arm && res_under;
    end
endmodule

// File: rtl/multi_ramp_counter.sv
// multi_ramp_counter: N-channel single-slope converter; owns ramp timing and publishes all counts per period
module multi_ramp_counter
  import multi_ramp_counter_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 7,
  parameter int MAX_COUNT   = 100,
  parameter int DIV         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       comp,
  output logic                    ramp_up,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       over,
  output logic [NUM_CH-1:0]       under,
  output logic                    sample_valid
);
  localparam int PW = clog2_min1(DIV);
  if (MAX_COUNT < 1 || MAX_COUNT >= 2 ** WIDTH || DIV < 1 || SYNC_STAGES < 2) begin : g_bad_params
    $error("multi_ramp_counter: invalid parameter set");
  end
  state_t state, state_nxt;
  logic [PW-1:0] psc;
  logic [WIDTH-1:0] cnt;
  logic tick, last, arm, publish;
  logic [NUM_CH*WIDTH-1:0] res_val;
  logic [NUM_CH-1:0] res_over, res_under;
  assign ramp_up = state == UP;
  always_comb begin
    tick = psc == PW'(DIV - 1);
    last = tick && cnt == WIDTH'(MAX_COUNT - 1);
    publish = en && state == UP && last;
    arm = en && (state == IDLE || (state == DOWN && last));
    state_nxt = !en ? IDLE : state == IDLE ? UP : !last ? state : state == UP ? DOWN : UP;
  end
  // dropping en clears the prescaler and count so the next UP always starts from zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      psc <= '0;
      cnt <= '0;
      count_out <= '0;
      over <= '0;
      under <= '0;
      sample_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      psc <= (state == IDLE || !en || tick) ? '0 : psc + PW'(1);
      cnt <= (state == IDLE || !en || last) ? '0 : tick ? cnt + WIDTH'(1) : cnt;
      sample_valid <= publish;
      if (publish) begin
        count_out <= res_val;
        over <= res_over;
        under <= res_under;
      end
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ramp_chan_capture #(
      .WIDTH(WIDTH),
      .MAX_COUNT(MAX_COUNT),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cap (
      .clk(clk),
      .reset(reset),
      .comp(comp[i]),
      .count(cnt),
      .arm(arm),
      .in_up(state == UP),
      .last_tick(publish),
      .res_val(res_val[i*WIDTH +: WIDTH]),
      .res_over(res_over[i]),
      .res_under(res_under[i])
    );
  end
endmodule

// File: tb/tb_multi_ramp_counter.sv
// tb_multi_ramp_counter: directed scoreboard bench for the two-channel ramp converter
module tb_multi_ramp_counter;
  localparam int NUM_CH = 2, WIDTH = 7, MAX_COUNT = 100, DIV = 4, SYNC_STAGES = 2;
  localparam int HALF = MAX_COUNT * DIV;
  typedef struct packed {
    logic [NUM_CH*WIDTH-1:0] cnt;
    logic [NUM_CH-1:0] over;
    logic [NUM_CH-1:0] under;
  } exp_t;
  logic clk = 1'b0;
  logic reset, en, ramp_up, sample_valid;
  logic [NUM_CH-1:0] comp, over, under;
  logic [NUM_CH*WIDTH-1:0] count_out;
  exp_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multi_ramp_counter #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .DIV(DIV), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .comp(comp), .ramp_up(ramp_up),
    .count_out(count_out), .over(over), .under(under), .sample_valid(sample_valid)
  );
  // f: clk after UP start at which comp falls; 0 = low throughout (under), <0 = never falls (over)
  function automatic exp_t model(input int f0, input int f1);
    exp_t e = '0;
    int f;
    for (int c = 0; c < NUM_CH; c++) begin
      f = (c == 0) ? f0 : f1;
      if (f == 0) e.under[c] = 1'b1;
      else if (f < 0 || f + SYNC_STAGES + 1 > HALF) begin
        e.cnt[c*WIDTH +: WIDTH] = WIDTH'(MAX_COUNT);
        e.over[c] = 1'b1;
      end else e.cnt[c*WIDTH +: WIDTH] = WIDTH'((f + SYNC_STAGES) / DIV);
    end
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic up_loop(input int f0, input int f1, input bit glitch);
    exp_t e;
    sb.push_back(model(f0, f1));
    for (int k = 1; k <= HALF; k++) begin
      @(posedge clk);
      #1;
      if (k == f0) comp[0] = 1'b0;
      if (k == f1) comp[1] = 1'b0;
      if (glitch && f0 > 0 && k == f0 + 40) comp[0] = 1'b1;
      if (glitch && f0 > 0 && k == f0 + 50) comp[0] = 1'b0;
      if (k == HALF - 1 || k == HALF) chk("ramp_up", ramp_up, k < HALF);
      if (sample_valid) begin
        chk("publish_cycle", k, HALF);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("count_out", count_out, e.cnt);
          chk("over", over, e.over);
          chk("under", under, e.under);
        end
      end
    end
    chk("pending_publish", sb.size(), 0);
    sb.delete();
  endtask
  task automatic start(input int f0, input int f1);
    comp = {f1 != 0, f0 != 0};
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;
    up_loop(f0, f1, 1'b0);
  endtask
  task automatic next_period(input int f0, input int f1, input bit glitch);
    comp = {f1 != 0, f0 != 0};
    repeat (HALF) @(posedge clk);
    #1;
    up_loop(f0, f1, glitch);
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_count"}, count_out, 0);
    chk({tag, "_flags"}, {over, under}, 0);
    chk({tag, "_sv"}, sample_valid, 0);
    chk({tag, "_ramp"}, ramp_up, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int sv, ru;
    reset = 1'b0;
    en = 1'b1;
    comp = '0;
    repeat (5) @(posedge clk);
    #1;
    chk_cleared("reset");
    reset = 1'b1;
    en = 1'b0;
    sv = 0;
    ru = 0;
    repeat (2000) begin
      @(posedge clk);
      #1;
      sv += int'(sample_valid);
      ru += int'(ramp_up);
    end
    chk("idle_sample_valid", sv, 0);
    chk("idle_ramp_up", ru, 0);
    start(160, 240);
    next_period(160, 240, 1'b0);
    next_period(-1, 0, 1'b0);
    next_period(397, 398, 1'b0);
    next_period(160, 240, 1'b1);
    comp = 2'b11;
    repeat (HALF) @(posedge clk);
    #1;
    repeat (200) @(posedge clk);
    #1;
    en = 1'b0;
    sv = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      sv += int'(sample_valid);
    end
    chk("abort_sample_valid", sv, 0);
    chk("abort_hold", count_out, model(160, 240).cnt);
    chk("abort_ramp_up", ramp_up, 0);
    start(100, 300);
    comp = 2'b11;
    repeat (HALF) @(posedge clk);
    #1;
    repeat (150) @(posedge clk);
    #1;
    reset = 1'b0;
    en = 1'b0;
    #1;
    chk_cleared("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    start(200, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
